// File: rtl/izigzag_row_sched.sv
// Row scheduler: round-robins eight row streams into one merged stream, ROW_LEN data tokens per turn,
// retires each stream on its end-of-stream token, then emits a single merged end-of-stream token.
module izigzag_row_sched #(
    parameter int WIDTH   = 16,
    parameter int ROW_LEN = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] chuA_d,
    input  logic             chuA_e,
    input  logic             chuA_v,
    output logic             chuA_b,
    input  logic [WIDTH-1:0] chuB_d,
    input  logic             chuB_e,
    input  logic             chuB_v,
    output logic             chuB_b,
    input  logic [WIDTH-1:0] chuC_d,
    input  logic             chuC_e,
    input  logic             chuC_v,
    output logic             chuC_b,
    input  logic [WIDTH-1:0] chuD_d,
    input  logic             chuD_e,
    input  logic             chuD_v,
    output logic             chuD_b,
    input  logic [WIDTH-1:0] chuE_d,
    input  logic             chuE_e,
    input  logic             chuE_v,
    output logic             chuE_b,
    input  logic [WIDTH-1:0] chuF_d,
    input  logic             chuF_e,
    input  logic             chuF_v,
    output logic             chuF_b,
    input  logic [WIDTH-1:0] chuG_d,
    input  logic             chuG_e,
    input  logic             chuG_v,
    output logic             chuG_b,
    input  logic [WIDTH-1:0] chuH_d,
    input  logic             chuH_e,
    input  logic             chuH_v,
    output logic             chuH_b,
    output logic [WIDTH-1:0] mrg_d,
    output logic             mrg_e,
    output logic             mrg_v,
    input  logic             mrg_b
);

    typedef enum logic [1:0] {SERVE, FLUSH, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(ROW_LEN - 1);

    state_t           state_q, state_d;
    logic [2:0]       cur_q, cur_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       done_q, done_d;
    logic [WIDTH-1:0] mrg_dat_q, mrg_dat_d;
    logic             mrg_eos_q, mrg_eos_d;
    logic             mrg_vld_q, mrg_vld_d;

    logic [WIDTH-1:0] in_dat [8];
    logic [7:0]       in_eos;
    logic [7:0]       in_vld;
    logic [7:0]       in_bp;
    logic             free;

    assign in_dat[0] = chuA_d;
    assign in_dat[1] = chuB_d;
    assign in_dat[2] = chuC_d;
    assign in_dat[3] = chuD_d;
    assign in_dat[4] = chuE_d;
    assign in_dat[5] = chuF_d;
    assign in_dat[6] = chuG_d;
    assign in_dat[7] = chuH_d;
    assign in_eos = {chuH_e, chuG_e, chuF_e, chuE_e, chuD_e, chuC_e, chuB_e, chuA_e};
    assign in_vld = {chuH_v, chuG_v, chuF_v, chuE_v, chuD_v, chuC_v, chuB_v, chuA_v};

    // First not-done index after 'from' going round; returns 'from' itself when it is the only one left.
    function automatic logic [2:0] next_open(input logic [2:0] from, input logic [7:0] mask);
        logic [2:0] res;
        logic [2:0] idx;
        res = from;
        for (int i = 8; i >= 1; i--) begin
            idx = from + 3'(i);
            if (!mask[idx]) res = idx;
        end
        return res;
    endfunction

    always_comb begin
        free      = !mrg_vld_q || !mrg_b;
        state_d   = state_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        mrg_dat_d = mrg_dat_q;
        mrg_eos_d = mrg_eos_q;
        mrg_vld_d = mrg_vld_q && mrg_b;
        in_bp     = '1;

        case (state_q)
            SERVE: begin
                in_bp[cur_q] = !free;
                if (in_vld[cur_q] && free) begin
                    if (!in_eos[cur_q]) begin
                        mrg_dat_d = in_dat[cur_q];
                        mrg_eos_d = 1'b0;
                        mrg_vld_d = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            cur_d = next_open(cur_q, done_q);
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        done_d = done_q | (8'b1 << cur_q);
                        cnt_d  = '0;
                        if (&done_d) state_d = FLUSH;
                        else         cur_d   = next_open(cur_q, done_d);
                    end
                end
            end
            FLUSH: begin
                if (free) begin
                    mrg_dat_d = '0;
                    mrg_eos_d = 1'b1;
                    mrg_vld_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (!mrg_vld_d) mrg_eos_d = 1'b0;
            end
            default: state_d = SERVE;
        endcase

        if (!reset) in_bp = '1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= SERVE;
            cur_q     <= '0;
            cnt_q     <= '0;
            done_q    <= '0;
            mrg_dat_q <= '0;
            mrg_eos_q <= 1'b0;
            mrg_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            mrg_dat_q <= mrg_dat_d;
            mrg_eos_q <= mrg_eos_d;
            mrg_vld_q <= mrg_vld_d;
        end
    end

    assign chuA_b = in_bp[0];
    assign chuB_b = in_bp[1];
    assign chuC_b = in_bp[2];
    assign chuD_b = in_bp[3];
    assign chuE_b = in_bp[4];
    assign chuF_b = in_bp[5];
    assign chuG_b = in_bp[6];
    assign chuH_b = in_bp[7];
    assign mrg_d  = mrg_dat_q;
    assign mrg_e  = mrg_eos_q;
    assign mrg_v  = mrg_vld_q;

endmodule

// File: doc/izigzag_row_sched.md
IZIGZAG_ROW_SCHED -- requirements
Module: izigzag_row_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of every stream.
REQ-002 SHALL have parameter ROW_LEN, default 8: data tokens granted per stream per turn; legal range 1..255.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have ports chuX_d, input, WIDTH, for X in A..H: row-stream data.
REQ-006 SHALL have ports chuX_e, input, 1: end-of-stream flag for the token on chuX_d.
REQ-007 SHALL have ports chuX_v, input, 1: chuX token valid.
REQ-008 SHALL have ports chuX_b, output, 1: backpressure to producer X; 1 = stall.
REQ-009 SHALL have port mrg_d, output, WIDTH: merged data.
REQ-010 SHALL have port mrg_e, output, 1: merged end-of-stream flag.
REQ-011 SHALL have port mrg_v, output, 1: merged token valid.
REQ-012 SHALL have port mrg_b, input, 1: backpressure from the consumer; 1 = stall.

Function
REQ-013 SHALL define a transfer on any stream as a cycle where its v=1 and its b=0.
REQ-014 SHALL hold a pointer cur (0..7, A=0), a counter cnt (0..ROW_LEN-1), an 8-bit done mask and a one-entry output register (mrg_d/mrg_e/mrg_v).
REQ-015 SHALL use FSM states SERVE, FLUSH and DONE.
REQ-016 SHALL treat the output register as free when mrg_v=0, or when mrg_v=1 and mrg_b=0 in the same cycle.
REQ-017 In SERVE, SHALL drive chu[cur]_b = not free, and chuX_b=1 for every X != cur.
REQ-018 On a transfer of a data token (e=0) from cur, SHALL load the token into the output register, so latency is exactly 1 cycle, and increment cnt.
REQ-019 When cnt reaches ROW_LEN, SHALL clear cnt and advance cur to the next index, mod 8, whose done bit is 0.
REQ-020 SHALL sustain 1 token/cycle while chu[cur]_v=1 and mrg_b=0, including across a rotation.
REQ-021 On a transfer of an e=1 token from cur, SHALL set done[cur], clear cnt, advance cur to the next not-done index and leave the output register unloaded; the e token SHALL NOT be forwarded.
REQ-022 SHALL skip done streams during rotation; with exactly one stream not done, cur SHALL stay on that stream and cnt SHALL still wrap at ROW_LEN.
REQ-023 When all 8 done bits become set, SHALL enter FLUSH.
REQ-024 In FLUSH, once the output register is free, SHALL load mrg_e=1, mrg_v=1, mrg_d=0, then enter DONE.
REQ-025 In DONE, SHALL hold the eos token until it transfers (mrg_b=0), then hold mrg_v=0; all chuX_b SHALL be 1 until reset.
REQ-026 While mrg_v=1 and mrg_b=1, SHALL hold mrg_d, mrg_e and mrg_v stable.
REQ-027 SHALL ignore chuX_v and chuX_e for X != cur.
REQ-028 SHALL NOT alter cnt or cur while chu[cur]_v=0 (a bubble).

Reset
REQ-029 While reset=0 at a clock edge, SHALL set state=SERVE, cur=0, cnt=0, done=0, mrg_v=0, mrg_e=0 and mrg_d=0.
REQ-030 SHALL drive all chuX_b=1 combinationally while reset=0.
REQ-031 A reset asserted mid-row or mid-FLUSH SHALL discard any held output token and restart at stream A with no token emitted.

Verification
REQ-032 All streams always valid, ROW_LEN=8, mrg_b=0, chuA..H carrying 0xA000+i .. 0xH000+i -> mrg emits A0..A7, B0..B7, ..., H0..H7, A8..A15, one token per cycle, with no gaps.
REQ-033 mrg_b held 1 for 5 cycles mid-row B -> mrg_d/mrg_v held stable, chuB_b=1 for those cycles, no token lost or duplicated, and the row count still ends at 8 B tokens.
REQ-034 chuC sends e=1 after 3 data tokens -> 3 C tokens are forwarded, the e token is not forwarded, the next grant goes to D, and later rotations skip C.
REQ-035 All 8 streams send e=1 -> exactly one mrg token with e=1 and d=0 appears, after which mrg_v=0 and all chuX_b=1 permanently.
REQ-036 chuA_v toggles 1,0,1,0 -> cnt advances only on valid cycles, and rotation to B occurs after the 8th A transfer.
REQ-037 reset=0 asserted for 1 cycle during row E with mrg_v=1 -> the next cycle shows mrg_v=0, and service resumes from stream A with cnt=0.
